// File: rtl/move_stack_pkg.sv
// Shared types for the make/undo engine. This package holds the piece codes,
// the move word layout, the LIFO entry and the op and FSM-state enums.
package move_stack_pkg;

  localparam int unsigned PIECE_W = 4;

  // Bit 3 marks the colour (0 = white, 1 = black); code 0 is an empty square.
  localparam logic [PIECE_W-1:0] PIECE_EMPTY = 4'd0;
  localparam logic [PIECE_W-1:0] W_PAWN      = 4'd1;
  localparam logic [PIECE_W-1:0] W_KNIGHT    = 4'd2;
  localparam logic [PIECE_W-1:0] W_BISHOP    = 4'd3;
  localparam logic [PIECE_W-1:0] W_ROOK      = 4'd4;
  localparam logic [PIECE_W-1:0] W_QUEEN     = 4'd5;
  localparam logic [PIECE_W-1:0] W_KING      = 4'd6;
  localparam logic [PIECE_W-1:0] B_PAWN      = 4'd9;
  localparam logic [PIECE_W-1:0] B_KNIGHT    = 4'd10;
  localparam logic [PIECE_W-1:0] B_BISHOP    = 4'd11;
  localparam logic [PIECE_W-1:0] B_ROOK      = 4'd12;
  localparam logic [PIECE_W-1:0] B_QUEEN     = 4'd13;
  localparam logic [PIECE_W-1:0] B_KING      = 4'd14;

  // Move word: [11:6] to square, [5:0] from square.
  typedef struct packed {
    logic [5:0] to;
    logic [5:0] from;
  } move_t;

  typedef struct packed {
    move_t              move;
    logic [PIECE_W-1:0] captured;
  } stack_entry_t;

  typedef enum logic {
    OP_MAKE = 1'b0,
    OP_UNDO = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WRITE
  } state_e;

endpackage

// File: rtl/move_stack_if.sv
// Command handshake between the search stage (master) and move_stack (slave).
//   cmd_valid/cmd_ready : request handshake, accepted when both are high
//   cmd_op              : OP_MAKE or OP_UNDO
//   cmd_move            : from/to squares; ignored for UNDO
//   done                : one-cycle completion pulse
//   err                 : one-cycle pulse with done when the command was rejected
interface move_stack_if;
  logic                  cmd_valid;
  logic                  cmd_ready;
  move_stack_pkg::op_e   cmd_op;
  move_stack_pkg::move_t cmd_move;
  logic                  done;
  logic                  err;

  modport master (output cmd_valid, cmd_op, cmd_move,
                  input  cmd_ready, done, err);
  modport slave  (input  cmd_valid, cmd_op, cmd_move,
                  output cmd_ready, done, err);
endinterface

// File: rtl/move_stack_ply_lifo.sv
// Register-based LIFO of made moves and their captured pieces.
//   i_push/i_pop : push i_data or drop the top; ignored when full/empty
//   i_clear      : empty the stack (count only)
//   o_top        : current top entry (undefined when empty)
//   o_count      : entries held; o_full/o_empty flags
// Only the count is reset. Entry contents are don't-care until pushed.
module ply_lifo
  import move_stack_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_clear,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  stack_entry_t               i_data,
  output stack_entry_t               o_top,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  stack_entry_t   r_mem [DEPTH];
  logic [CW-1:0]  r_count;
  logic [AW-1:0]  w_top_idx;
  logic [AW-1:0]  w_wr_idx;

  // With DEPTH a power of two the low count bits wrap to 0 when full,
  // so count-1 still lands on the last slot.
  assign w_wr_idx  = r_count[AW-1:0];
  assign w_top_idx = r_count[AW-1:0] - AW'(1);

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_top   = r_mem[w_top_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_push && !o_full) begin
      r_count <= r_count + CW'(1);
    end else if (i_pop && !o_empty) begin
      r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!i_clear && i_push && !o_full) begin
      r_mem[w_wr_idx] <= i_data;
    end
  end

endmodule

// File: rtl/move_stack.sv
// Make/undo engine for the minimax search. It holds the working board,
// applies MAKE commands and reverts them with UNDO, and keeps the captured
// pieces on a LIFO.
//   clk, rst_n      : clock, async active-low reset
//   load_valid      : in IDLE, copy board_in/side_in and clear ply
//   board_in        : flattened board, square s at [s*PW +: PW]
//   side_in         : side to move after load (1 = white)
//   cmd             : command handshake (move_stack_if.slave)
//   board_out       : current board
//   white_to_move   : current side
//   ply             : moves outstanding
//   last_captured   : captured piece of the most recent completed command
module move_stack
  import move_stack_pkg::*;
#(
  parameter int unsigned MAX_PLY = 8,
  parameter int unsigned PW      = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load_valid,
  input  logic [64*PW-1:0]          board_in,
  input  logic                      side_in,
  move_stack_if.slave               cmd,
  output logic [64*PW-1:0]          board_out,
  output logic                      white_to_move,
  output logic [$clog2(MAX_PLY):0]  ply,
  output logic [PW-1:0]             last_captured
);

  state_e                  r_state;
  logic                    r_ready;
  logic                    r_done;
  logic                    r_err;
  logic [63:0][PW-1:0]     r_board;
  logic                    r_side;
  logic [PW-1:0]           r_last_cap;
  op_e                     r_op;
  move_t                   r_move;
  logic [PW-1:0]           r_piece_from;
  logic [PW-1:0]           r_piece_to;
  logic                    r_reject;

  logic                    w_clear;
  logic                    w_push;
  logic                    w_pop;
  stack_entry_t            w_entry;
  stack_entry_t            w_top;
  logic                    w_full;
  logic                    w_empty;
  logic [$clog2(MAX_PLY):0] w_count;

  assign w_clear = (r_state == ST_IDLE) && load_valid;
  assign w_push  = (r_state == ST_WRITE) && !r_reject && (r_op == OP_MAKE);
  assign w_pop   = (r_state == ST_WRITE) && !r_reject && (r_op == OP_UNDO);
  assign w_entry = '{move: r_move, captured: PIECE_W'(r_piece_to)};

  ply_lifo #(.DEPTH(MAX_PLY)) u_lifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_clear),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_entry),
    .o_top   (w_top),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_ready      <= 1'b1;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_board      <= '0;
      r_side       <= 1'b1;
      r_last_cap   <= '0;
      r_op         <= OP_MAKE;
      r_move       <= '0;
      r_piece_from <= '0;
      r_piece_to   <= '0;
      r_reject     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (load_valid) begin
            r_board    <= board_in;
            r_side     <= side_in;
            r_last_cap <= '0;
          end else if (cmd.cmd_valid) begin
            r_op    <= cmd.cmd_op;
            r_move  <= cmd.cmd_move;
            r_ready <= 1'b0;
            r_state <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (r_op == OP_MAKE) begin
            r_piece_from <= r_board[r_move.from];
            r_piece_to   <= r_board[r_move.to];
            r_reject     <= w_full || (r_move.from == r_move.to) ||
                            (r_board[r_move.from] == '0);
          end else begin
            // UNDO takes its squares from the stack, not from cmd_move;
            // r_piece_to carries the piece to restore.
            r_move     <= w_top.move;
            r_piece_to <= PW'(w_top.captured);
            r_reject   <= w_empty;
          end
          r_state <= ST_WRITE;
        end
        ST_WRITE: begin
          if (!r_reject) begin
            if (r_op == OP_MAKE) begin
              r_board[r_move.to]   <= r_piece_from;
              r_board[r_move.from] <= '0;
            end else begin
              r_board[r_move.from] <= r_board[r_move.to];
              r_board[r_move.to]   <= r_piece_to;
            end
            r_side     <= ~r_side;
            r_last_cap <= r_piece_to;
          end
          r_done  <= 1'b1;
          r_err   <= r_reject;
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign cmd.cmd_ready  = r_ready;
  assign cmd.done       = r_done;
  assign cmd.err        = r_err;
  assign board_out      = r_board;
  assign white_to_move  = r_side;
  assign ply            = w_count;
  assign last_captured  = r_last_cap;

endmodule
